game_line_tx: RTL
=================

// Module: game_line_tx
// PURPOSE
//  Serializer for the cube-game record format "Game <id>: <n> <color>, <n> <color>; ...\n".
//  Accepts one structured draw (count, color, set/game terminators) per handshake.
//  Emits the ASCII byte stream one char per beat, consumable directly by the line parsers.
//  Used as a stimulus source and loopback partner for the parser blocks.
// PARAMETERS
//  START_ID   1   game id printed on the first line after reset; increments per game, 8-bit wrap
// PORTS
//  clk            in   1  clock
//  rst_n          in   1  asynchronous active-low reset
//  draw_valid     in   1  draw fields valid
//  draw_ready     out  1  block accepts a draw this cycle
//  draw_count     in   8  cube count, 0..255, printed in decimal
//  draw_color     in   2  color code from the shared package
//  draw_end_set   in   1  draw closes its set (separator "; ")
//  draw_end_game  in   1  draw closes the game (newline); overrides draw_end_set
//  char_out       out  8  ASCII byte
//  char_valid     out  1  char_out valid
//  char_ready     in   1  downstream accepts char_out
//  game_id_out    out  8  id of the game currently being (or next to be) emitted
// BEHAVIOUR
//  Reset: state IDLE, char_valid=0, char_out=0, game_id_out=START_ID, in_game=0, draw_ready=1.
//  draw_ready = (state==IDLE); draw fields latched on draw_valid&&draw_ready.
//  Output handshake: char_valid/char_out hold stable until char_ready; a char advances on valid&&ready.
//  Latency: draw accepted in cycle N -> first char_valid in N+1; 1 char/cycle while char_ready=1.
//  FSM: IDLE -> (in_game=0 ? HDR : NUM) on accept.
//   HDR : "Game " (5 chars) -> ID
//   ID  : decimal game id, leading zeros suppressed -> COL
//   COL : ": " -> NUM; sets in_game=1
//   NUM : decimal count, leading zeros suppressed; count 0 emits "0" -> SP
//   SP  : ' ' -> CLR
//   CLR : "red"/"green"/"blue"; code 3 emits "red" -> SEP
//   SEP : end_game -> '\n', game_id+1 (255 wraps to 0), in_game=0;
//         else end_set -> "; "; else ", " -> IDLE after the last sep char is accepted
//  draw_ready is low for the whole emission; no draw is buffered.
//  draw_end_set && draw_end_game -> newline only.
//  Reset mid-line: partial line discarded, no trailing newline, id returns to START_ID.
//  char_ready is ignored while char_valid=0.
// CONFIGURATION
//  GAME_LINE_TX_CRLF_EN defined: game terminator is "\r\n" (0x0D then 0x0A).
//  Not defined: terminator is '\n' (0x0A) only. No other behaviour changes.
// STRUCTURE
//  Shared package (aoc_pkg):
//   - color_e {RED=0, GREEN=1, BLUE=2}, same encoding as the parsers
//   - ASCII constants: SPACE 32, COLON 58, COMMA 44, SEMI 59, LF 10, CR 13, ZERO 48
//  Sub-module byte_to_bcd:
//   - combinational 8-bit -> 3 BCD digits plus digit count (1..3)
//   - shared by the ID and NUM states
//  Word tables ("Game ", color names) are indexed by a char counter inside the FSM.
// TESTING
//  1 basic line: START_ID=1; draws (3,BLUE,0,0),(4,RED,1,0),(1,RED,0,0),(2,GREEN,0,1)
//    -> "Game 1: 3 blue, 4 red; 1 red, 2 green\n"; game_id_out=2 afterwards.
//  2 digit widths: single-draw games with counts 0, 9, 10, 255
//    -> "0", "9", "10", "255"; consecutive ids, no leading zeros.
//  3 backpressure: char_ready toggling 1010... and a random pattern
//    -> byte stream identical to test 1; char_out stable while valid&&!ready.
//  4 id wrap: START_ID=254, three one-draw games -> ids "254", "255", "0".
//  5 reset mid-line: assert rst_n=0 after "Game 1: 1" is emitted
//    -> char_valid=0 immediately; next game restarts "Game 1: ".
//  6 loopback: feed output into the part-1 parser with the test-1 stream plus "Game 2: 20 red\n"
//    -> parser result=1; repeat with GAME_LINE_TX_CRLF_EN and check 0x0D precedes every 0x0A.

Source files
------------

// File: rtl/aoc_pkg.sv
// ============================================================================
// Module : aoc_pkg
// Brief  : Shared colour codes, ASCII constants and word tables for the game-line blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aoc_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_e;

  localparam logic [7:0] c_space = 8'd32;
  localparam logic [7:0] c_colon = 8'd58;
  localparam logic [7:0] c_comma = 8'd44;
  localparam logic [7:0] c_semi  = 8'd59;
  localparam logic [7:0] c_lf    = 8'd10;
  localparam logic [7:0] c_cr    = 8'd13;
  localparam logic [7:0] c_zero  = 8'd48;

  function automatic logic [7:0] hdr_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return "G";
      3'd1:    return "a";
      3'd2:    return "m";
      3'd3:    return "e";
      default: return c_space;
    endcase
  endfunction

  // Code 3 is unused by the parsers and is printed as "red".
  function automatic logic [2:0] color_len(input logic [1:0] code);
    case (code)
      GREEN:   return 3'd5;
      BLUE:    return 3'd4;
      default: return 3'd3;
    endcase
  endfunction

  function automatic logic [7:0] color_char(input logic [1:0] code, input logic [2:0] idx);
    case (code)
      GREEN: begin
        case (idx)
          3'd0:    return "g";
          3'd1:    return "r";
          3'd2:    return "e";
          3'd3:    return "e";
          default: return "n";
        endcase
      end
      BLUE: begin
        case (idx)
          3'd0:    return "b";
          3'd1:    return "l";
          3'd2:    return "u";
          default: return "e";
        endcase
      end
      default: begin
        case (idx)
          3'd0:    return "r";
          3'd1:    return "e";
          default: return "d";
        endcase
      end
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_line_tx_if.sv
// ============================================================================
// Module : game_line_tx_if
// Brief  : Draw-input and character-output handshakes of the game-line serializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface game_line_tx_if;
  logic       draw_valid;
  logic       draw_ready;
  logic [7:0] draw_count;
  logic [1:0] draw_color;
  logic       draw_end_set;
  logic       draw_end_game;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output draw_valid, draw_count, draw_color, draw_end_set, draw_end_game, char_ready,
    input  draw_ready, char_out, char_valid
  );

  modport slave (
    input  draw_valid, draw_count, draw_color, draw_end_set, draw_end_game, char_ready,
    output draw_ready, char_out, char_valid
  );
endinterface

`default_nettype wire

// File: rtl/game_line_tx_bcd.sv
// ============================================================================
// Module : byte_to_bcd
// Brief  : Combinational 8-bit binary to three BCD digits plus significant-digit count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_to_bcd (
  input  logic [7:0] i_value,
  output logic [3:0] o_hund,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [1:0] o_ndig
);

  logic [11:0] w_bcd;

  // Shift-and-add-3; the hundreds digit never exceeds 2 so it needs no correction.
  always_comb begin
    w_bcd = 12'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_bcd[3:0] >= 4'd5) w_bcd[3:0] = w_bcd[3:0] + 4'd3;
      if (w_bcd[7:4] >= 4'd5) w_bcd[7:4] = w_bcd[7:4] + 4'd3;
      w_bcd = {w_bcd[10:0], i_value[i]};
    end
  end

  assign o_hund = w_bcd[11:8];
  assign o_tens = w_bcd[7:4];
  assign o_ones = w_bcd[3:0];
  assign o_ndig = (o_hund != 4'd0) ? 2'd3 : ((o_tens != 4'd0) ? 2'd2 : 2'd1);

endmodule

`default_nettype wire

// File: rtl/game_line_tx.sv
// ============================================================================
// Module : game_line_tx
// Brief  : Serializes structured draws into "Game <id>: <n> <color>, ...; ...\n" ASCII.
//          GAME_LINE_TX_CRLF_EN selects a "\r\n" game terminator instead of "\n".
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module game_line_tx
  import aoc_pkg::*;
#(
  parameter logic [7:0] START_ID = 8'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  game_line_tx_if.slave bus,
  output logic [7:0]    game_id_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_COL  = 3'd3;
  localparam logic [2:0] S_NUM  = 3'd4;
  localparam logic [2:0] S_SP   = 3'd5;
  localparam logic [2:0] S_CLR  = 3'd6;
  localparam logic [2:0] S_SEP  = 3'd7;

  logic [2:0] r_state;
  logic [2:0] r_idx;
  logic [7:0] r_count;
  logic [1:0] r_color;
  logic       r_end_set;
  logic       r_end_game;
  logic [7:0] r_game_id;
  logic       r_in_game;

  logic [7:0] w_num;
  logic [3:0] w_hund, w_tens, w_ones, w_digit;
  logic [1:0] w_ndig, w_pos;
  logic [7:0] w_char;
  logic       w_last;
  logic       w_fire;
  logic       w_accept;

  assign w_num = (r_state == S_ID) ? r_game_id : r_count;

  byte_to_bcd u_bcd (
    .i_value (w_num),
    .o_hund  (w_hund),
    .o_tens  (w_tens),
    .o_ones  (w_ones),
    .o_ndig  (w_ndig)
  );

  // Offset the char counter so the first printed digit is the most significant non-zero one.
  assign w_pos = r_idx[1:0] + (2'd3 - w_ndig);

  always_comb begin
    case (w_pos)
      2'd0:    w_digit = w_hund;
      2'd1:    w_digit = w_tens;
      default: w_digit = w_ones;
    endcase
  end

  always_comb begin
    w_char = 8'd0;
    w_last = 1'b0;
    case (r_state)
      S_HDR: begin
        w_char = hdr_char(r_idx);
        w_last = (r_idx == 3'd4);
      end
      S_ID, S_NUM: begin
        w_char = c_zero + {4'd0, w_digit};
        w_last = (r_idx == {1'b0, w_ndig - 2'd1});
      end
      S_COL: begin
        w_char = (r_idx == 3'd0) ? c_colon : c_space;
        w_last = (r_idx == 3'd1);
      end
      S_SP: begin
        w_char = c_space;
        w_last = 1'b1;
      end
      S_CLR: begin
        w_char = color_char(r_color, r_idx);
        w_last = (r_idx == color_len(r_color) - 3'd1);
      end
      S_SEP: begin
        if (r_end_game) begin
`ifdef GAME_LINE_TX_CRLF_EN
          w_char = (r_idx == 3'd0) ? c_cr : c_lf;
          w_last = (r_idx == 3'd1);
`else
          w_char = c_lf;
          w_last = 1'b1;
`endif
        end else begin
          w_char = (r_idx == 3'd0) ? (r_end_set ? c_semi : c_comma) : c_space;
          w_last = (r_idx == 3'd1);
        end
      end
      default: ;
    endcase
  end

  assign bus.char_out   = w_char;
  assign bus.char_valid = (r_state != S_IDLE);
  assign bus.draw_ready = (r_state == S_IDLE);
  assign game_id_out    = r_game_id;

  assign w_accept = bus.draw_valid && bus.draw_ready;
  assign w_fire   = bus.char_valid && bus.char_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_count    <= 8'd0;
      r_color    <= 2'd0;
      r_end_set  <= 1'b0;
      r_end_game <= 1'b0;
      r_game_id  <= START_ID;
      r_in_game  <= 1'b0;
    end else if (w_accept) begin
      r_count    <= bus.draw_count;
      r_color    <= bus.draw_color;
      r_end_set  <= bus.draw_end_set;
      r_end_game <= bus.draw_end_game;
      r_idx      <= 3'd0;
      r_state    <= r_in_game ? S_NUM : S_HDR;
    end else if (w_fire) begin
      if (!w_last) begin
        r_idx <= r_idx + 3'd1;
      end else begin
        r_idx <= 3'd0;
        case (r_state)
          S_HDR: r_state <= S_ID;
          S_ID:  r_state <= S_COL;
          S_COL: begin
            r_state   <= S_NUM;
            r_in_game <= 1'b1;
          end
          S_NUM: r_state <= S_SP;
          S_SP:  r_state <= S_CLR;
          S_CLR: r_state <= S_SEP;
          S_SEP: begin
            r_state <= S_IDLE;
            if (r_end_game) begin
              r_game_id <= r_game_id + 8'd1;
              r_in_game <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
